// File: rtl/cdec8_mem_io.sv
// cdec8_mem_io: address decode, 240-byte RAM, LED/switch/timer I/O page and a
// byte-stream program loader that holds the core in reset while filling RAM.
`timescale 1ns/1ps
module cdec8_mem_io #(
  parameter int PRESCALE = 16
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic [7:0] adrs,
  input  logic [7:0] wdata,
  input  logic       mmwr_en,
  output logic [7:0] rdata,
  input  logic [7:0] sw,
  output logic [7:0] led,
  input  logic       load_mode,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       cpu_rst_N
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]    RAM_LAST = 8'hEF;
  localparam logic [7:0]    A_LED    = 8'hF0;
  localparam logic [7:0]    A_SW     = 8'hF1;
  localparam logic [7:0]    A_TCNT   = 8'hF2;
  localparam logic [7:0]    A_TCTL   = 8'hF3;
  localparam logic [7:0]    A_TCMP   = 8'hF4;
  localparam logic [7:0]    A_STAT   = 8'hF5;

  logic [7:0]    ram_q [0:239];
  logic [7:0]    led_q, led_d;
  logic [7:0]    sw_s1_q, sw_s2_q;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [7:0]    tcmp_q, tcmp_d;
  logic [7:0]    ld_ptr_q, ld_ptr_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          en_q, en_d;
  logic          match_q, match_d;
  logic          lm_prev_q;
  logic          cpu_rst_q;

  logic          core_wr, ld_wr, lm_rise, tick, clr;
  logic [7:0]    ld_adrs;

  // Write qualification: the loader owns the bus while load_mode is high.
  // A load_mode rising edge restarts the pointer at 0x00 in the same cycle.
  always_comb begin
    core_wr = mmwr_en & ~load_mode;
    ld_wr   = load_mode & ld_valid;
    lm_rise = load_mode & ~lm_prev_q;
    ld_adrs = lm_rise ? 8'h00 : ld_ptr_q;
    tick    = en_q && (pre_q == PRE_LAST);
    clr     = core_wr && (adrs == A_TCTL) && wdata[1];
  end

  // Next-state for I/O registers, timer and loader pointer. CLR beats a tick;
  // a MATCH set beats a coincident MATCH-clear write.
  always_comb begin
    led_d    = led_q;
    en_d     = en_q;
    tcmp_d   = tcmp_q;
    tcnt_d   = tcnt_q;
    pre_d    = pre_q;
    match_d  = match_q;
    ld_ptr_d = ld_adrs;
    if (core_wr) begin
      case (adrs)
        A_LED:   led_d  = wdata;
        A_TCTL:  en_d   = wdata[0];
        A_TCMP:  tcmp_d = wdata;
        A_STAT:  if (wdata[0]) match_d = 1'b0;
        default: ;
      endcase
    end
    if (clr) begin
      tcnt_d = 8'h00;
      pre_d  = '0;
    end else if (en_q) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (tcnt_q == tcmp_q) begin
          tcnt_d  = 8'h00;
          match_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
    end
    if (ld_wr) ld_ptr_d = (ld_adrs == RAM_LAST) ? 8'h00 : ld_adrs + 8'd1;
  end

  // Control/status registers, switch synchronizer and core reset.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      led_q     <= 8'h00;
      sw_s1_q   <= 8'h00;
      sw_s2_q   <= 8'h00;
      tcnt_q    <= 8'h00;
      tcmp_q    <= 8'hFF;
      en_q      <= 1'b0;
      match_q   <= 1'b0;
      pre_q     <= '0;
      ld_ptr_q  <= 8'h00;
      lm_prev_q <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      tcnt_q    <= tcnt_d;
      tcmp_q    <= tcmp_d;
      en_q      <= en_d;
      match_q   <= match_d;
      pre_q     <= pre_d;
      ld_ptr_q  <= ld_ptr_d;
      lm_prev_q <= load_mode;
      cpu_rst_q <= ~load_mode;
    end
  end

  // RAM write port, shared by loader and core (never both in one cycle).
  always_ff @(posedge clock) begin
    if (ld_wr) begin
      ram_q[ld_adrs] <= ld_data;
    end else if (core_wr && (adrs < 8'hF0)) begin
      ram_q[adrs] <= wdata;
    end
  end

  // Combinational read mux; unmapped I/O addresses read zero.
  always_comb begin
    rdata = 8'h00;
    if (adrs < 8'hF0) begin
      rdata = ram_q[adrs];
    end else begin
      case (adrs)
        A_LED:   rdata = led_q;
        A_SW:    rdata = sw_s2_q;
        A_TCNT:  rdata = tcnt_q;
        A_TCTL:  rdata = {7'b0, en_q};
        A_TCMP:  rdata = tcmp_q;
        A_STAT:  rdata = {7'b0, match_q};
        default: rdata = 8'h00;
      endcase
    end
  end

  assign led       = led_q;
  assign ld_ready  = load_mode;
  assign cpu_rst_N = cpu_rst_q;

endmodule

// File: tb/tb_cdec8_mem_io.sv
// Bench for cdec8_mem_io: behavioural model checked every cycle, plus
// hand-computed literal expectations along a directed sequence.
`timescale 1ns/1ps
module tb_cdec8_mem_io;

  localparam int PRESCALE = 4;

  logic       clock = 1'b0;
  logic       reset_N;
  logic [7:0] adrs, wdata, sw, ld_data, rdata, led;
  logic       mmwr_en, load_mode, ld_valid, ld_ready, cpu_rst_N;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  cdec8_mem_io #(.PRESCALE(PRESCALE)) dut (
    .clock(clock), .reset_N(reset_N), .adrs(adrs), .wdata(wdata),
    .mmwr_en(mmwr_en), .rdata(rdata), .sw(sw), .led(led),
    .load_mode(load_mode), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .cpu_rst_N(cpu_rst_N)
  );

  always #10 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [0:255];
  bit         m_known [0:255];
  logic [7:0] m_led, m_tcnt, m_tcmp, m_s1, m_s2;
  bit         m_en, m_match, m_lmprev, m_cpu;
  int         m_pre, m_ptr;
  int         t_ptr;
  bit         t_cwr, t_tick, t_clr, t_set;

  initial for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

  always @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      m_led = 8'h00; m_tcnt = 8'h00; m_tcmp = 8'hFF; m_s1 = 8'h00; m_s2 = 8'h00;
      m_en = 0; m_match = 0; m_lmprev = 0; m_cpu = 0; m_pre = 0; m_ptr = 0;
    end else begin
      t_cwr = mmwr_en && !load_mode;
      t_ptr = (load_mode && !m_lmprev) ? 0 : m_ptr;
      if (load_mode && ld_valid) begin
        m_mem[t_ptr] = ld_data; m_known[t_ptr] = 1'b1;
        t_ptr = (t_ptr + 1) % 240;
      end else if (t_cwr && adrs < 8'd240) begin
        m_mem[adrs] = wdata; m_known[adrs] = 1'b1;
      end
      m_ptr = t_ptr;
      t_tick = m_en && (m_pre == PRESCALE - 1);
      t_clr  = t_cwr && adrs == 8'hF3 && wdata[1];
      t_set  = 0;
      if (t_clr) begin
        m_tcnt = 0; m_pre = 0;
      end else if (m_en) begin
        m_pre = (m_pre + 1) % PRESCALE;
        if (t_tick) begin
          if (m_tcnt == m_tcmp) begin m_tcnt = 0; t_set = 1; end
          else m_tcnt = 8'(m_tcnt + 1);
        end
      end
      if (t_cwr && adrs == 8'hF5 && wdata[0]) m_match = 0;
      if (t_set) m_match = 1;
      if (t_cwr && adrs == 8'hF0) m_led = wdata;
      if (t_cwr && adrs == 8'hF3) m_en = wdata[0];
      if (t_cwr && adrs == 8'hF4) m_tcmp = wdata;
      m_s2 = m_s1; m_s1 = sw;
      m_cpu = !load_mode; m_lmprev = load_mode;
    end
  end

  function automatic logic [7:0] mread(input logic [7:0] a);
    if (a < 8'd240) return m_mem[a];
    case (a)
      8'hF0: return m_led;
      8'hF1: return m_s2;
      8'hF2: return m_tcnt;
      8'hF3: return {7'b0, m_en};
      8'hF4: return m_tcmp;
      8'hF5: return {7'b0, m_match};
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%02h expected=%02h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      if (adrs >= 8'd240 || m_known[adrs]) check("model_rdata", rdata, mread(adrs));
      check("model_led", led, m_led);
      check("model_ld_ready", {7'b0, ld_ready}, {7'b0, load_mode});
      check("model_cpu_rst_N", {7'b0, cpu_rst_N}, {7'b0, m_cpu});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    adrs = a;
    #1;
    check(nm, rdata, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    adrs = a; wdata = d; mmwr_en = 1'b1;
    cyc(1);
    mmwr_en = 1'b0;
  endtask

  initial begin
    reset_N = 1'b1; adrs = 8'hF0; wdata = 8'h00; mmwr_en = 1'b0; sw = 8'h00;
    load_mode = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    #1 reset_N = 1'b0;
    chk_en = 1'b1;
    cyc(2);
    // reset state
    check("rst_cpu_rst_N", {7'b0, cpu_rst_N}, 8'h00);
    rd(8'hF4, 8'hFF, "rst_tcmp");
    rd(8'hF0, 8'h00, "rst_led");
    rd(8'hF6, 8'h00, "rst_unmapped");
    reset_N = 1'b1;
    #1 check("rel_cpu_still_low", {7'b0, cpu_rst_N}, 8'h00);
    cyc(1);
    check("rel_cpu_high", {7'b0, cpu_rst_N}, 8'h01);

    // loader: 241 bytes from 0x10, core write to LED attempted mid-load
    for (int i = 0; i < 241; i++) begin
      load_mode = 1'b1; ld_valid = 1'b1; ld_data = 8'(16 + i);
      adrs = 8'hF0; wdata = 8'h5A; mmwr_en = (i == 5);
      #1;
      if (i == 1 || i == 240) begin
        check("ld_ready", {7'b0, ld_ready}, 8'h01);
        check("ld_cpu_held", {7'b0, cpu_rst_N}, 8'h00);
      end
      cyc(1);
    end
    load_mode = 1'b0; ld_valid = 1'b0; mmwr_en = 1'b0;
    #1 check("ld_led_untouched", led, 8'h00);
    check("ld_cpu_held_end", {7'b0, cpu_rst_N}, 8'h00);
    cyc(1);
    check("ld_cpu_release", {7'b0, cpu_rst_N}, 8'h01);
    rd(8'h00, 8'h00, "ram00_wrapped");
    rd(8'h01, 8'h11, "ram01");
    rd(8'hEF, 8'hFF, "ramEF");
    cyc(1);

    // I/O registers
    wr(8'hF0, 8'hA5);
    #1 check("led_a5", led, 8'hA5);
    wr(8'hF2, 8'h55);
    rd(8'hF2, 8'h00, "tcnt_ro");
    sw = 8'h3C;
    rd(8'hF1, 8'h00, "sw_edge0");
    cyc(1);
    rd(8'hF1, 8'h00, "sw_edge1");
    cyc(1);
    rd(8'hF1, 8'h3C, "sw_edge2");

    // RAM top and unmapped write
    wr(8'hEF, 8'h77);
    wr(8'hF6, 8'h88);
    rd(8'hEF, 8'h77, "ramEF_77");
    rd(8'hF6, 8'h00, "f6_zero");
    cyc(1);

    // timer: TCMP=2, EN=1, ticks every 4 cycles
    wr(8'hF4, 8'h02);
    wr(8'hF3, 8'h01);
    for (int k = 1; k <= 13; k++) begin
      cyc(1);
      rd(8'hF2, (k < 12) ? 8'(k / 4) : 8'h00, "tmr_tcnt");
      rd(8'hF5, (k < 12) ? 8'h00 : 8'h01, "tmr_match");
    end
    wr(8'hF5, 8'h01);                       // edge 14
    rd(8'hF5, 8'h00, "match_cleared");
    cyc(9);                                 // edge 23
    wr(8'hF5, 8'h01);                       // edge 24: tick sets MATCH
    rd(8'hF5, 8'h01, "match_set_wins");
    rd(8'hF2, 8'h00, "tcnt_wrap24");
    cyc(3);                                 // edge 27
    wr(8'hF3, 8'h03);                       // edge 28: CLR on tick
    rd(8'hF2, 8'h00, "clr_beats_tick");
    rd(8'hF3, 8'h01, "tctl_clr_reads0");
    cyc(3);
    rd(8'hF2, 8'h00, "post_clr_hold");
    cyc(1);
    rd(8'hF2, 8'h01, "post_clr_tick");

    // asynchronous reset mid-count
    cyc(2);
    reset_N = 1'b0;
    rd(8'hF2, 8'h00, "arst_tcnt");
    rd(8'hF3, 8'h00, "arst_en");
    rd(8'hF4, 8'hFF, "arst_tcmp");
    check("arst_led", led, 8'h00);
    check("arst_cpu", {7'b0, cpu_rst_N}, 8'h00);
    cyc(1);
    reset_N = 1'b1;
    cyc(1);
    rd(8'hEF, 8'h77, "ram_retained");
    check("arst_cpu_release", {7'b0, cpu_rst_N}, 8'h01);
    cyc(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
